// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_param
// Purpose  : Serial pattern detector with a loadable PAT_W-bit pattern,
//            overlap selection, a registered match pulse and a saturating
//            match counter.
// Revision : 1.0  initial release
// ============================================================================
module seq_detect_param #(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PAT_RST = PAT_W'(4'b1011),
  parameter int                CNT_W   = 8,
  localparam int               FILL_W  = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inp_bit,
  input  logic              inp_valid,
  input  logic              overlap_en,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_in,
  input  logic              cnt_clr,
  output logic              seq_seen,
  output logic [CNT_W-1:0]  match_count,
  output logic [FILL_W-1:0] fill_level
);

  localparam logic [FILL_W-1:0] c_fill_max = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] c_fill_pre = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max  = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              seq_seen_q, seq_seen_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;

  logic              accept;
  logic [PAT_W-1:0]  hist_shift;
  logic              match;

  // A load in the same cycle as a valid bit discards that bit.
  assign accept     = inp_valid & ~pat_load;
  assign hist_shift = {hist_q[PAT_W-2:0], inp_bit};
  assign match      = accept && (fill_q >= c_fill_pre) && (hist_shift == pattern_q);

  always_comb begin
    pattern_d     = pattern_q;
    hist_d        = hist_q;
    fill_d        = fill_q;
    seq_seen_d    = 1'b0;
    match_count_d = match_count_q;

    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      if (match && !overlap_en) begin
        fill_d = '0;
      end else if (fill_q != c_fill_max) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end

    seq_seen_d = match;

    // Clear takes priority over a coincident match.
    if (cnt_clr) begin
      match_count_d = '0;
    end else if (match && (match_count_q != c_cnt_max)) begin
      match_count_d = match_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q     <= PAT_RST;
      hist_q        <= '0;
      fill_q        <= '0;
      seq_seen_q    <= 1'b0;
      match_count_q <= '0;
    end else begin
      pattern_q     <= pattern_d;
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      seq_seen_q    <= seq_seen_d;
      match_count_q <= match_count_d;
    end
  end

  assign seq_seen    = seq_seen_q;
  assign match_count = match_count_q;
  assign fill_level  = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_param
// Purpose  : Directed self-checking bench for seq_detect_param.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_detect_param;

  logic       clk;
  logic       reset;
  logic       inp_bit;
  logic       inp_valid;
  logic       overlap_en;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;

  logic       seq_seen;
  logic [7:0] match_count;
  logic [2:0] fill_level;

  logic       seq_seen2;
  logic [1:0] match_count2;
  logic [2:0] fill_level2;

  int checks   = 0;
  int failures = 0;

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .inp_bit     (inp_bit),
    .inp_valid   (inp_valid),
    .overlap_en  (overlap_en),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .cnt_clr     (cnt_clr),
    .seq_seen    (seq_seen),
    .match_count (match_count),
    .fill_level  (fill_level)
  );

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .inp_bit     (inp_bit),
    .inp_valid   (inp_valid),
    .overlap_en  (overlap_en),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .cnt_clr     (cnt_clr),
    .seq_seen    (seq_seen2),
    .match_count (match_count2),
    .fill_level  (fill_level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, return 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic b, input logic pl, input logic cc);
    @(negedge clk);
    inp_valid = v;
    inp_bit   = b;
    pat_load  = pl;
    cnt_clr   = cc;
    @(posedge clk);
    #1;
    inp_valid = 1'b0;
    pat_load  = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Feed n valid bits (MSB first) and check seq_seen after each one.
  task automatic run_seq(input string tag, input logic [15:0] bits,
                         input logic [15:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 1'b0);
      check(tag, 32'(seq_seen), 32'(exp[i]));
    end
  endtask

  initial begin
    reset      = 1'b1;
    inp_bit    = 1'b0;
    inp_valid  = 1'b0;
    overlap_en = 1'b1;
    pat_load   = 1'b0;
    pat_in     = 4'b1011;
    cnt_clr    = 1'b0;

    // 1: reset state and a single match of the default pattern
    do_reset();
    check("rst_seen",  32'(seq_seen),    32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_fill",  32'(fill_level),  32'd0);
    run_seq("t1_seen", 16'b1011, 16'b0001, 4);
    check("t1_count", 32'(match_count), 32'd1);
    check("t1_fill",  32'(fill_level),  32'd4);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_drop", 32'(seq_seen), 32'd0);

    // 2a: overlapping matches
    do_reset();
    overlap_en = 1'b1;
    run_seq("t2a_seen", 16'b1011011, 16'b0001001, 7);
    check("t2a_count", 32'(match_count), 32'd2);

    // 2b: non-overlapping
    do_reset();
    overlap_en = 1'b0;
    run_seq("t2b_seen", 16'b1011011, 16'b0001000, 7);
    check("t2b_count", 32'(match_count), 32'd1);
    check("t2b_fill",  32'(fill_level),  32'd3);

    // 3: load 1111, overlapping then non-overlapping
    do_reset();
    overlap_en = 1'b1;
    pat_in     = 4'b1111;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_load_fill", 32'(fill_level), 32'd0);
    run_seq("t3a_seen", 16'b1111111, 16'b0001111, 7);
    check("t3a_count", 32'(match_count), 32'd4);
    overlap_en = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_reload_fill", 32'(fill_level), 32'd0);
    run_seq("t3b_seen", 16'b1111111, 16'b0001000, 7);
    check("t3b_count", 32'(match_count), 32'd5);
    check("t3b_fill",  32'(fill_level),  32'd3);

    // 4: idle gaps between bits
    do_reset();
    overlap_en = 1'b1;
    pat_in     = 4'b1011;
    drive(1'b1, 1'b1, 1'b0, 1'b0); check("t4_seen_a", 32'(seq_seen), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0); check("t4_seen_b", 32'(seq_seen), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0); check("t4_seen_c", 32'(seq_seen), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); check("t4_seen_d", 32'(seq_seen), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); check("t4_seen_e", 32'(seq_seen), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0); check("t4_seen_f", 32'(seq_seen), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); check("t4_seen_g", 32'(seq_seen), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0); check("t4_seen_h", 32'(seq_seen), 32'd0);
    check("t4_count", 32'(match_count), 32'd1);

    // 4 rerun: load coincident with the completing bit wins
    do_reset();
    run_seq("t4r_seen", 16'b101, 16'b000, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("t4r_load_seen", 32'(seq_seen),    32'd0);
    check("t4r_load_fill", 32'(fill_level),  32'd0);
    check("t4r_count",     32'(match_count), 32'd0);

    // 5: saturating 2-bit counter and clear-wins
    do_reset();
    overlap_en = 1'b1;
    pat_in     = 4'b1111;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("t5_pre_seen", 32'(seq_seen2), 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("t5_seen",  32'(seq_seen2),    32'd1);
      check("t5_count", 32'(match_count2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check("t5_wide_count", 32'(match_count), 32'd6);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_clr_seen",  32'(seq_seen2),    32'd1);
    check("t5_clr_count", 32'(match_count2), 32'd0);
    check("t5_clr_wide",  32'(match_count),  32'd0);
    check("t5_fill",      32'(fill_level2),  32'd4);

    // 6: asynchronous reset between edges
    do_reset();
    overlap_en = 1'b0;
    pat_in     = 4'b1011;
    run_seq("t6_pre", 16'b1011101, 16'b0001000, 7);
    check("t6_pre_count", 32'(match_count), 32'd1);
    check("t6_pre_fill",  32'(fill_level),  32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_fill",  32'(fill_level),  32'd0);
    check("t6_async_count", 32'(match_count), 32'd0);
    check("t6_async_seen",  32'(seq_seen),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_post_seen", 32'(seq_seen),   32'd0);
    check("t6_post_fill", 32'(fill_level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
